// File: rtl/hs_io_buffer_pkg.sv
// Shared state encodings and default parameters for the buffered I/O handshake block.
package hs_io_buffer_pkg;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_DEPTH       = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic {
    RxIdle,
    RxAck
  } rx_state_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxReq,
    TxWaitLow
  } tx_state_e;

endpackage

// File: rtl/hs_sync_fifo.sv
// Single-clock FIFO; full/empty come from the registered count, pointers wrap mod DEPTH.
module hs_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  // A push while full is dropped even when a pop frees a slot this cycle.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/hs_io_buffer.sv
// Buffered four-phase req/ack bridge: RX queue from the external producer, TX queue to the
// external consumer, with synchronised req/ack inputs and sticky misuse flags.
module hs_io_buffer
  import hs_io_buffer_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [WIDTH-1:0]       i_in,
  input  logic                   i_in_data_ready,
  output logic                   o_in_ack,
  output logic [WIDTH-1:0]       o_out,
  output logic                   o_out_data_ready,
  input  logic                   i_out_ack,
  input  logic                   i_rx_rd,
  output logic [WIDTH-1:0]       o_rx_data,
  output logic                   o_rx_empty,
  output logic [$clog2(DEPTH):0] o_rx_count,
  input  logic                   i_tx_wr,
  input  logic [WIDTH-1:0]       i_tx_wdata,
  output logic                   o_tx_full,
  input  logic                   i_err_clr,
  output logic                   o_rx_underflow,
  output logic                   o_tx_overflow
);

  logic [SYNC_STAGES-1:0] r_req_sync;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_req_s;
  logic                   w_ack_s;

  rx_state_e        r_rx_state, w_rx_state_d;
  logic             r_in_ack, w_in_ack_d;
  logic             w_rx_push;
  logic             w_rx_full;

  tx_state_e        r_tx_state, w_tx_state_d;
  logic [WIDTH-1:0] r_out, w_out_d;
  logic             r_out_data_ready, w_out_data_ready_d;
  logic             w_tx_pop;
  logic [WIDTH-1:0] w_tx_head;
  logic             w_tx_empty;
  logic [$clog2(DEPTH):0] w_unused_tx_count;

  logic             r_rx_underflow;
  logic             r_tx_overflow;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_sync <= '0;
      r_ack_sync <= '0;
    end else begin
      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], i_in_data_ready};
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_out_ack};
    end
  end

  assign w_req_s = r_req_sync[SYNC_STAGES-1];
  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  hs_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_rx_push),
    .i_pop   (i_rx_rd),
    .i_wdata (i_in),
    .o_rdata (o_rx_data),
    .o_count (o_rx_count),
    .o_full  (w_rx_full),
    .o_empty (o_rx_empty)
  );

  hs_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_tx_wr),
    .i_pop   (w_tx_pop),
    .i_wdata (i_tx_wdata),
    .o_rdata (w_tx_head),
    .o_count (w_unused_tx_count),
    .o_full  (o_tx_full),
    .o_empty (w_tx_empty)
  );

  // A full RX queue holds off the acknowledge, which backpressures the producer.
  always_comb begin
    w_rx_state_d = r_rx_state;
    w_in_ack_d   = r_in_ack;
    w_rx_push    = 1'b0;
    case (r_rx_state)
      RxIdle: if (w_req_s && !w_rx_full) begin
        w_rx_push    = 1'b1;
        w_in_ack_d   = 1'b1;
        w_rx_state_d = RxAck;
      end
      RxAck: if (!w_req_s) begin
        w_in_ack_d   = 1'b0;
        w_rx_state_d = RxIdle;
      end
      default: w_rx_state_d = RxIdle;
    endcase
  end

  // The head is popped only on acknowledge so it stays valid while the request is up.
  always_comb begin
    w_tx_state_d       = r_tx_state;
    w_out_d            = r_out;
    w_out_data_ready_d = r_out_data_ready;
    w_tx_pop           = 1'b0;
    case (r_tx_state)
      TxIdle: if (!w_tx_empty) begin
        w_out_d            = w_tx_head;
        w_out_data_ready_d = 1'b1;
        w_tx_state_d       = TxReq;
      end
      TxReq: if (w_ack_s) begin
        w_out_data_ready_d = 1'b0;
        w_tx_pop           = 1'b1;
        w_tx_state_d       = TxWaitLow;
      end
      TxWaitLow: if (!w_ack_s) w_tx_state_d = TxIdle;
      default: w_tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_state       <= RxIdle;
      r_in_ack         <= 1'b0;
      r_tx_state       <= TxIdle;
      r_out            <= '0;
      r_out_data_ready <= 1'b0;
    end else begin
      r_rx_state       <= w_rx_state_d;
      r_in_ack         <= w_in_ack_d;
      r_tx_state       <= w_tx_state_d;
      r_out            <= w_out_d;
      r_out_data_ready <= w_out_data_ready_d;
    end
  end

  // A new error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_underflow <= 1'b0;
      r_tx_overflow  <= 1'b0;
    end else begin
      if (i_rx_rd && o_rx_empty) r_rx_underflow <= 1'b1;
      else if (i_err_clr)        r_rx_underflow <= 1'b0;
      if (i_tx_wr && o_tx_full)  r_tx_overflow  <= 1'b1;
      else if (i_err_clr)        r_tx_overflow  <= 1'b0;
    end
  end

  assign o_in_ack         = r_in_ack;
  assign o_out            = r_out;
  assign o_out_data_ready = r_out_data_ready;
  assign o_rx_underflow   = r_rx_underflow;
  assign o_tx_overflow    = r_tx_overflow;

endmodule

// File: tb/tb_hs_io_buffer.sv
// Directed bench for hs_io_buffer with default parameters (WIDTH=8, DEPTH=4, SYNC_STAGES=2).
module tb_hs_io_buffer;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_data_ready;
  logic       in_ack;
  logic [7:0] out_data;
  logic       out_data_ready;
  logic       out_ack;
  logic       rx_rd;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic [2:0] rx_count;
  logic       tx_wr;
  logic [7:0] tx_wdata;
  logic       tx_full;
  logic       err_clr;
  logic       rx_underflow;
  logic       tx_overflow;

  int n_pass  = 0;
  int n_total = 0;

  hs_io_buffer dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_in             (in_data),
    .i_in_data_ready  (in_data_ready),
    .o_in_ack         (in_ack),
    .o_out            (out_data),
    .o_out_data_ready (out_data_ready),
    .i_out_ack        (out_ack),
    .i_rx_rd          (rx_rd),
    .o_rx_data        (rx_data),
    .o_rx_empty       (rx_empty),
    .o_rx_count       (rx_count),
    .i_tx_wr          (tx_wr),
    .i_tx_wdata       (tx_wdata),
    .o_tx_full        (tx_full),
    .i_err_clr        (err_clr),
    .o_rx_underflow   (rx_underflow),
    .o_tx_overflow    (tx_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_in_ack(input logic val, input string tag);
    int n = 0;
    while (in_ack !== val && n < 50) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, in_ack}, {31'd0, val});
  endtask

  task automatic wait_odr(input logic val, input string tag);
    int n = 0;
    while (out_data_ready !== val && n < 50) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, out_data_ready}, {31'd0, val});
  endtask

  task automatic rx_send(input logic [7:0] d);
    in_data       = d;
    in_data_ready = 1'b1;
    wait_in_ack(1'b1, "rx_send_ack_hi");
    in_data_ready = 1'b0;
    wait_in_ack(1'b0, "rx_send_ack_lo");
  endtask

  task automatic rx_pop(input logic [7:0] exp, input string tag);
    chk(tag, {24'd0, rx_data}, {24'd0, exp});
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
  endtask

  task automatic tx_ack();
    out_ack = 1'b1;
    wait_odr(1'b0, "tx_ack_odr_lo");
    out_ack = 1'b0;
    tick(4);
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_data_ready = 1'b0; out_ack = 1'b0;
    rx_rd = 1'b0; tx_wr = 1'b0; tx_wdata = '0; err_clr = 1'b0;
    tick(2);
    chk("rst_in_ack",   {31'd0, in_ack},         32'd0);
    chk("rst_odr",      {31'd0, out_data_ready}, 32'd0);
    chk("rst_out",      {24'd0, out_data},       32'd0);
    chk("rst_rx_empty", {31'd0, rx_empty},       32'd1);
    chk("rst_rx_count", {29'd0, rx_count},       32'd0);
    chk("rst_tx_full",  {31'd0, tx_full},        32'd0);
    chk("rst_flags",    {30'd0, rx_underflow, tx_overflow}, 32'd0);
    rst_n = 1'b1;
    tick();

    // RX single word with exact SYNC_STAGES+1 latency each way
    in_data = 8'hA5; in_data_ready = 1'b1;
    tick(2);
    chk("rx1_ack_early", {31'd0, in_ack}, 32'd0);
    tick();
    chk("rx1_ack_hi", {31'd0, in_ack}, 32'd1);
    in_data_ready = 1'b0;
    tick(2);
    chk("rx1_ack_still_hi", {31'd0, in_ack}, 32'd1);
    tick();
    chk("rx1_ack_lo", {31'd0, in_ack}, 32'd0);
    chk("rx1_count", {29'd0, rx_count}, 32'd1);
    rx_pop(8'hA5, "rx1_data");
    chk("rx1_empty_after", {31'd0, rx_empty}, 32'd1);

    // RX backpressure
    for (int i = 1; i <= 4; i++) rx_send(8'(i));
    chk("bp_count4", {29'd0, rx_count}, 32'd4);
    in_data = 8'h05; in_data_ready = 1'b1;
    tick(10);
    chk("bp_ack_held_lo", {31'd0, in_ack}, 32'd0);
    chk("bp_count_still4", {29'd0, rx_count}, 32'd4);
    rx_pop(8'h01, "bp_pop01");
    wait_in_ack(1'b1, "bp_05_accepted");
    chk("bp_count_refill", {29'd0, rx_count}, 32'd4);
    in_data_ready = 1'b0;
    wait_in_ack(1'b0, "bp_ack_lo");
    rx_pop(8'h02, "bp_pop02");
    rx_pop(8'h03, "bp_pop03");
    rx_pop(8'h04, "bp_pop04");
    rx_pop(8'h05, "bp_pop05");
    chk("bp_empty", {31'd0, rx_empty}, 32'd1);

    // TX drain
    tx_wr = 1'b1; tx_wdata = 8'h3C; tick();
    tx_wdata = 8'hC3; tick();
    tx_wr = 1'b0;
    chk("tx_out_3c", {24'd0, out_data}, 32'h3C);
    chk("tx_odr_hi", {31'd0, out_data_ready}, 32'd1);
    chk("tx_not_full", {31'd0, tx_full}, 32'd0);
    out_ack = 1'b1;
    tick(2);
    chk("tx_odr_before_ack", {31'd0, out_data_ready}, 32'd1);
    tick();
    chk("tx_odr_dropped", {31'd0, out_data_ready}, 32'd0);
    out_ack = 1'b0;
    wait_odr(1'b1, "tx_second_req");
    chk("tx_out_c3", {24'd0, out_data}, 32'hC3);
    chk("tx_not_full2", {31'd0, tx_full}, 32'd0);
    tx_ack();
    chk("tx_idle", {31'd0, out_data_ready}, 32'd0);
    chk("tx_out_holds", {24'd0, out_data}, 32'hC3);

    // Overflow: outACK held low so the first word is never popped
    tx_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_wdata = 8'h10 + 8'(i);
      tick();
    end
    tx_wr = 1'b0;
    chk("ovf_flag", {31'd0, tx_overflow}, 32'd1);
    chk("ovf_full", {31'd0, tx_full}, 32'd1);
    chk("ovf_out10", {24'd0, out_data}, 32'h10);
    tx_ack();
    for (int i = 1; i < 4; i++) begin
      wait_odr(1'b1, "ovf_drain_req");
      chk("ovf_drain_data", {24'd0, out_data}, 32'h10 + 32'(i));
      tx_ack();
    end
    tick(6);
    chk("ovf_14_never_sent", {31'd0, out_data_ready}, 32'd0);
    chk("ovf_last_out", {24'd0, out_data}, 32'h13);

    // Underflow, clear, and set-wins-over-clear
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    chk("udf_flag", {31'd0, rx_underflow}, 32'd1);
    rx_rd = 1'b1; err_clr = 1'b1; tick(); rx_rd = 1'b0;
    chk("udf_set_wins", {31'd0, rx_underflow}, 32'd1);
    chk("ovf_cleared_alone", {31'd0, tx_overflow}, 32'd0);
    tick(); err_clr = 1'b0;
    chk("udf_cleared", {31'd0, rx_underflow}, 32'd0);

    // Simultaneous push/pop at count 2 across pointer wrap
    rx_send(8'h20);
    rx_send(8'h21);
    for (int k = 0; k < 10; k++) begin
      in_data = 8'h22 + 8'(k); in_data_ready = 1'b1;
      tick(2);
      chk("sim_head", {24'd0, rx_data}, 32'h20 + 32'(k));
      rx_rd = 1'b1; tick(); rx_rd = 1'b0;
      chk("sim_count2", {29'd0, rx_count}, 32'd2);
      in_data_ready = 1'b0;
      wait_in_ack(1'b0, "sim_ack_lo");
    end
    rx_pop(8'h2A, "sim_tail0");
    rx_pop(8'h2B, "sim_tail1");
    chk("sim_empty", {31'd0, rx_empty}, 32'd1);

    // Reset during TX_REQ
    rx_send(8'h66);
    tx_wr = 1'b1; tx_wdata = 8'h55; tick(); tx_wr = 1'b0;
    wait_odr(1'b1, "mrst_req");
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_odr", {31'd0, out_data_ready}, 32'd0);
    chk("mrst_out", {24'd0, out_data}, 32'd0);
    chk("mrst_tx_full", {31'd0, tx_full}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("mrst_rx_empty", {31'd0, rx_empty}, 32'd1);
    chk("mrst_rx_count", {29'd0, rx_count}, 32'd0);
    chk("mrst_no_tx", {31'd0, out_data_ready}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
